// File: rtl/etc_pkg.sv
// Shared types and op encodings for the extended-tensor-core tile sequencer.
package etc_pkg;

   localparam int unsigned EtcW = 16;

   typedef logic [3:0][3:0][EtcW-1:0] tile_t;

   // Combine ops, cmd_op[2:0]; any code above CombMin selects AND.
   localparam logic [2:0] CombMul  = 3'b000;
   localparam logic [2:0] CombPlus = 3'b001;
   localparam logic [2:0] CombL2   = 3'b010;
   localparam logic [2:0] CombMax  = 3'b011;
   localparam logic [2:0] CombMin  = 3'b100;
   localparam logic [2:0] CombAnd  = 3'b101;

   // Reduce ops, cmd_op[4:3].
   localparam logic [1:0] RedPlus = 2'b00;
   localparam logic [1:0] RedMin  = 2'b01;
   localparam logic [1:0] RedMax  = 2'b10;
   localparam logic [1:0] RedOr   = 2'b11;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

   // Reduce identity is either all zeros or all ones; only min needs all ones.
   function automatic logic identityOnes(input logic [1:0] rop);
      return rop == RedMin;
   endfunction

endpackage

// File: rtl/etc_reduce_tile.sv
// Lane-wise 16-element reduce of a partial tile into the accumulator tile.
module etc_reduce_tile
   import etc_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic [16*W-1:0] acc,
   input  logic [16*W-1:0] tileIn,
   input  logic [1:0]      rop,
   output logic [16*W-1:0] res
);

   logic [W-1:0] a;
   logic [W-1:0] b;

   // Apply the reduce op independently to each of the 16 lanes, unsigned.
   always_comb begin
      res = '0;
      a   = '0;
      b   = '0;
      for (int l = 0; l < 16; l++) begin
         a = acc[l*W +: W];
         b = tileIn[l*W +: W];
         unique case (rop)
            RedPlus: res[l*W +: W] = a + b;
            RedMin:  res[l*W +: W] = (b < a) ? b : a;
            RedMax:  res[l*W +: W] = (b > a) ? b : a;
            RedOr:   res[l*W +: W] = a | b;
            default: res[l*W +: W] = a;
         endcase
      end
   end

endmodule

// File: rtl/etc_tile_sequencer.sv
// Drives one 4x4 semiring MMA core through a K-loop of A/B tile pairs and
// folds the partial results into a single accumulated output tile.
module etc_tile_sequencer
   import etc_pkg::*;
#(
   parameter int unsigned W        = 16,
   parameter int unsigned KW       = 8,
   parameter int unsigned CORE_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [4:0]        cmd_op,
   input  logic [KW-1:0]     cmd_ktiles,
   input  logic              tile_valid,
   output logic              tile_ready,
   input  logic [16*W-1:0]   tile_a,
   input  logic [16*W-1:0]   tile_b,
   output logic [4:0]        core_op,
   output logic [16*W-1:0]   core_inA,
   output logic [16*W-1:0]   core_inB,
   input  logic [16*W-1:0]   core_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [16*W-1:0]   res_data,
   output logic              busy
);

   state_t                state;
   logic [KW-1:0]         ktiles;
   logic [KW-1:0]         issued;
   logic [KW-1:0]         captured;
   logic [CORE_LAT-1:0]   validPipe;
   logic [16*W-1:0]       reduced;
   logic                  tileFire;
   logic                  cmdFire;
   logic                  capture;

   assign core_inA = tile_a;
   assign core_inB = tile_b;
   assign tileFire = tile_valid & tile_ready;
   assign cmdFire  = cmd_valid & cmd_ready;
   // Pipe output marks the cycle the matching core result is sampleable.
   assign capture  = validPipe[CORE_LAT-1];

   etc_reduce_tile #(
      .W(W)
   ) uReduce (
      .acc    (res_data),
      .tileIn (core_out),
      .rop    (core_op[4:3]),
      .res    (reduced)
   );

   // FSM, issue/capture counters, valid pipe and accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         cmd_ready  <= 1'b1;
         tile_ready <= 1'b0;
         res_valid  <= 1'b0;
         busy       <= 1'b0;
         res_data   <= '0;
         core_op    <= '0;
         ktiles     <= '0;
         issued     <= '0;
         captured   <= '0;
         validPipe  <= '0;
      end else begin
         validPipe[0] <= tileFire;
         for (int i = 1; i < CORE_LAT; i++) begin
            validPipe[i] <= validPipe[i-1];
         end

         if (capture) begin
            res_data <= reduced;
            captured <= captured + 1'b1;
         end

         unique case (state)
            StIdle: begin
               if (cmdFire) begin
                  core_op   <= cmd_op;
                  ktiles    <= cmd_ktiles;
                  issued    <= '0;
                  captured  <= '0;
                  res_data  <= {(16*W){identityOnes(cmd_op[4:3])}};
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (cmd_ktiles == '0) begin
                     state     <= StDone;
                     res_valid <= 1'b1;
                  end else begin
                     state      <= StRun;
                     tile_ready <= 1'b1;
                  end
               end
            end
            StRun: begin
               if (tileFire) begin
                  issued <= issued + 1'b1;
                  if (issued == ktiles - 1'b1) begin
                     tile_ready <= 1'b0;
                     state      <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (captured == ktiles) begin
                  state     <= StDone;
                  res_valid <= 1'b1;
               end
            end
            StDone: begin
               if (res_ready) begin
                  state     <= StIdle;
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
